// File: rtl/error_response_arbiter_pkg.sv
// Shared definitions for the error response arbiter: header field constants
// and FSM state encoding.
package error_response_arbiter_pkg;

  localparam int SIZE_OF_HEADER_VARS     = 4;
  // Bits per header field; the header is SIZE_OF_HEADER_VARS fields wide.
  localparam int SIZE_OF_HEADER_IN_BYTES = 8;
  localparam int HEADER_W = SIZE_OF_HEADER_VARS * SIZE_OF_HEADER_IN_BYTES;

  localparam logic [7:0] PROTOCOL_VERSION = 8'h01;
  localparam logic [7:0] ERROR_RESP_CMD   = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } arb_state_t;

endpackage

// File: rtl/error_response_arbiter_err_prio_enc.sv
// Fixed-priority encoder: reports the highest set request index and whether
// any request is set.
module err_prio_enc #(
  parameter int NUM_ERR = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_ERR-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < NUM_ERR; i++) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/error_response_arbiter.sv
// Arbitrates edge-triggered error requests into single error-response headers,
// with ack timeout, bounded retries and coalescing of repeated requests.
module error_response_arbiter
  import error_response_arbiter_pkg::*;
#(
  parameter int                     NUM_ERR     = 5,
  parameter logic [8*NUM_ERR-1:0]   ERR_PARAM1  = {8'h01, 8'h01, 8'h03, 8'h02, 8'h04},
  parameter logic [8*NUM_ERR-1:0]   ERR_PARAM2  = {8'h00, 8'h00, 8'h00, 8'h01, 8'h00},
  parameter int                     ACK_TIMEOUT = 16,
  parameter int                     MAX_RETRY   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  input  logic [NUM_ERR-1:0]  Error_req,
  input  logic                MSG_ack,
  output logic [HEADER_W-1:0] header,
  output logic                payload,
  output logic                MSG_ready,
  output logic                Msg_dropped,
  output logic [7:0]          Coalesce_cnt
);

  localparam int IDX_W   = (NUM_ERR > 1) ? $clog2(NUM_ERR) : 1;
  localparam int WAIT_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  arb_state_t          state, state_next;
  logic [NUM_ERR-1:0]  req_prev, pending, pending_next, rise, coal;
  logic [IDX_W-1:0]    sel_idx, cur_idx, retry_idx;
  logic                sel_vld;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [RETRY_W-1:0]  retry_cnt;
  logic                retry_ok;
  logic                load, ack_hit, timeout_hit;
  logic [8:0]          coal_n;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [8:0] b);
    logic [9:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] param_byte(input logic [8*NUM_ERR-1:0] vec,
                                            input logic [IDX_W-1:0]    i);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < NUM_ERR; k++) begin
      if (IDX_W'(k) == i) b = vec[8*k +: 8];
    end
    return b;
  endfunction

  assign rise     = Error_req & ~req_prev;
  assign coal     = rise & pending;
  assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRY));
  assign payload  = 1'b0;

  err_prio_enc #(
    .NUM_ERR (NUM_ERR),
    .IDX_W   (IDX_W)
  ) u_prio (
    .req (pending),
    .idx (sel_idx),
    .vld (sel_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Ack has priority over a timeout falling in the same cycle.
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_vld) begin
          load       = 1'b1;
          state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (MSG_ack) begin
          ack_hit    = 1'b1;
          state_next = ST_GAP;
        end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = ST_GAP;
        end
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (!Enable) begin
      state_next  = ST_IDLE;
      load        = 1'b0;
      ack_hit     = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  always_comb begin
    MSG_ready = (state == ST_PRESENT);
    header    = '0;
    if (state == ST_PRESENT) begin
      header = {PROTOCOL_VERSION, ERROR_RESP_CMD,
                param_byte(ERR_PARAM1, cur_idx), param_byte(ERR_PARAM2, cur_idx)};
    end
  end

  // A new edge is applied after the clear so it wins over the load.
  always_comb begin
    pending_next = pending;
    if (load) pending_next[sel_idx] = 1'b0;
    if (timeout_hit && retry_ok) pending_next[cur_idx] = 1'b1;
    pending_next = pending_next | rise;
    coal_n = 9'd0;
    for (int k = 0; k < NUM_ERR; k++) coal_n = coal_n + 9'(coal[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_prev     <= '0;
      pending      <= '0;
      wait_cnt     <= '0;
      retry_cnt    <= '0;
      retry_idx    <= '0;
      Msg_dropped  <= 1'b0;
      Coalesce_cnt <= 8'h00;
    end else begin
      req_prev    <= Error_req;
      Msg_dropped <= 1'b0;
      if (!Enable) begin
        pending   <= '0;
        wait_cnt  <= '0;
        retry_cnt <= '0;
      end else begin
        pending      <= pending_next;
        Coalesce_cnt <= sat_add8(Coalesce_cnt, coal_n);
        if (state == ST_PRESENT && !ack_hit && !timeout_hit) wait_cnt <= wait_cnt + WAIT_W'(1);
        else                                                 wait_cnt <= '0;
        if (load && (sel_idx != retry_idx)) retry_cnt <= '0;
        if (ack_hit) retry_cnt <= '0;
        if (timeout_hit) begin
          if (retry_ok) begin
            retry_cnt <= retry_cnt + RETRY_W'(1);
            retry_idx <= cur_idx;
          end else begin
            retry_cnt   <= '0;
            Msg_dropped <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) cur_idx <= sel_idx;
  end

endmodule

// File: tb/tb_error_response_arbiter.sv
// Scoreboard bench for error_response_arbiter: directed scenarios queue the
// expected presentations/drops; a negedge monitor checks what the DUT emits.
module tb_error_response_arbiter;

  logic        clk;
  logic        reset;
  logic        Enable;
  logic [4:0]  Error_req;
  logic        MSG_ack;
  logic [31:0] header;
  logic        payload;
  logic        MSG_ready;
  logic        Msg_dropped;
  logic [7:0]  Coalesce_cnt;

  typedef struct {
    bit          drop;
    logic [31:0] hdr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic ready_d  = 1'b0;

  error_response_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .Enable       (Enable),
    .Error_req    (Error_req),
    .MSG_ack      (MSG_ack),
    .header       (header),
    .payload      (payload),
    .MSG_ready    (MSG_ready),
    .Msg_dropped  (Msg_dropped),
    .Coalesce_cnt (Coalesce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] hdr(input logic [7:0] p1, input logic [7:0] p2);
    return {8'h01, 8'h7F, p1, p2};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_msg(input logic [7:0] p1, input logic [7:0] p2);
    exp_t e;
    e.drop = 1'b0;
    e.hdr  = hdr(p1, p2);
    sb.push_back(e);
  endtask

  task automatic push_drop();
    exp_t e;
    e.drop = 1'b1;
    e.hdr  = 32'h0;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every new presentation and every drop pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (MSG_ready && !ready_d) begin
      if (sb.size() == 0) begin
        check("unexpected_presentation", header, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("presentation_kind", 32'(e.drop), 32'd0);
        check("presentation_header", header, e.hdr);
      end
    end
    if (Msg_dropped) begin
      if (sb.size() == 0) begin
        check("unexpected_drop", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("drop_kind", 32'(e.drop), 32'd1);
      end
    end
    ready_d = MSG_ready;
  end

  initial begin
    int rc;
    int dc;
    reset     = 1'b1;
    Enable    = 1'b0;
    Error_req = 5'b0;
    MSG_ack   = 1'b0;
    tick(2);
    check("reset_ready", 32'(MSG_ready), 32'd0);
    check("reset_header", header, 32'h0);
    check("reset_dropped", 32'(Msg_dropped), 32'd0);
    check("reset_coalesce", 32'(Coalesce_cnt), 32'd0);
    check("payload_zero", 32'(payload), 32'd0);
    reset  = 1'b0;
    Enable = 1'b1;
    tick(1);

    // Single source 1 edge with ack held high.
    MSG_ack = 1'b1;
    push_msg(8'h02, 8'h01);
    Error_req = 5'b00010;
    tick(1);
    Error_req = 5'b0;
    check("t1_ready_not_yet", 32'(MSG_ready), 32'd0);
    tick(1);
    check("t1_ready_up", 32'(MSG_ready), 32'd1);
    check("t1_header", header, hdr(8'h02, 8'h01));
    tick(1);
    check("t1_gap_ready", 32'(MSG_ready), 32'd0);
    check("t1_gap_header", header, 32'h0);
    tick(1);
    check("t1_idle_ready", 32'(MSG_ready), 32'd0);
    tick(4);

    // Sources 0 and 4 rise together: 4 first, then 0.
    push_msg(8'h01, 8'h00);
    push_msg(8'h04, 8'h00);
    Error_req = 5'b10001;
    tick(1);
    Error_req = 5'b0;
    tick(10);

    // No ack: three 16-cycle presentations of source 2, then a drop.
    MSG_ack = 1'b0;
    push_msg(8'h03, 8'h00);
    push_msg(8'h03, 8'h00);
    push_msg(8'h03, 8'h00);
    push_drop();
    Error_req = 5'b00100;
    rc = 0;
    dc = 0;
    for (int i = 0; i < 70; i++) begin
      tick(1);
      Error_req = 5'b0;
      if (MSG_ready) rc++;
      if (Msg_dropped) dc++;
    end
    check("t3_ready_cycles", 32'(rc), 32'd48);
    check("t3_drop_pulses", 32'(dc), 32'd1);
    check("t3_coalesce_zero", 32'(Coalesce_cnt), 32'd0);

    // Source 2 re-raised three times while pending behind source 4.
    push_msg(8'h01, 8'h00);
    push_msg(8'h03, 8'h00);
    Error_req = 5'b10000;
    tick(1);
    Error_req = 5'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      Error_req = 5'b00100;
      tick(1);
      Error_req = 5'b0;
      tick(1);
    end
    check("t4_coalesce", 32'(Coalesce_cnt), 32'd3);
    MSG_ack = 1'b1;
    tick(20);
    MSG_ack = 1'b0;

    // Ack in the timeout cycle counts as ack: no re-presentation.
    push_msg(8'h01, 8'h00);
    Error_req = 5'b01000;
    tick(1);
    Error_req = 5'b0;
    tick(1);
    check("t5_ready_up", 32'(MSG_ready), 32'd1);
    tick(15);
    check("t5_ready_last", 32'(MSG_ready), 32'd1);
    MSG_ack = 1'b1;
    tick(1);
    MSG_ack = 1'b0;
    check("t5_ready_down", 32'(MSG_ready), 32'd0);
    tick(30);

    // Reset during PRESENT.
    push_msg(8'h02, 8'h01);
    Error_req = 5'b00010;
    tick(1);
    Error_req = 5'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("t6_ready", 32'(MSG_ready), 32'd0);
    check("t6_header", header, 32'h0);
    check("t6_dropped", 32'(Msg_dropped), 32'd0);
    check("t6_coalesce", 32'(Coalesce_cnt), 32'd0);
    reset = 1'b0;
    tick(30);

    // Enable dropped during PRESENT with a coalesced request outstanding.
    push_msg(8'h01, 8'h00);
    Error_req = 5'b10000;
    tick(1);
    Error_req = 5'b0;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      Error_req = 5'b00001;
      tick(1);
      Error_req = 5'b0;
      tick(1);
    end
    check("t7_coalesce_pre", 32'(Coalesce_cnt), 32'd1);
    Enable = 1'b0;
    tick(1);
    check("t7_ready", 32'(MSG_ready), 32'd0);
    check("t7_header", header, 32'h0);
    check("t7_dropped", 32'(Msg_dropped), 32'd0);
    check("t7_coalesce_hold", 32'(Coalesce_cnt), 32'd1);
    Enable = 1'b1;
    rc = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (MSG_ready) rc++;
    end
    check("t7_no_presentation", 32'(rc), 32'd0);
    check("t7_coalesce_after", 32'(Coalesce_cnt), 32'd1);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
